apb_req_bridge: RTL and testbench

Converts the core-side request/grant peripheral protocol (req/gnt with a separate r_valid response phase) into a single APB3 master transfer stream. Sits directly upstream of the APB node and drives its slave port; the node then decodes the address and forwards the transfer to one of the peripheral masters. Bridges one outstanding transfer at a time and bounds every transfer with a pready timeout that returns an error instead of hanging the core.

---
 rtl/apb_req_bridge_pkg.sv | 17 +
 rtl/apb_req_bridge_if.sv | 24 ++
 rtl/apb_req_bridge.sv | 123 ++++++++++++
 tb/tb_apb_req_bridge.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_req_bridge_pkg.sv
// Shared types and constants for the req/gnt to APB3 bridge.
package apb_req_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int TIMEOUT_RDATA = 0;

  // A zero timeout still needs a one-bit counter so the register is legal.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_req_bridge_if.sv
// APB3 bus between the bridge (master) and the downstream APB node (slave).
interface apb_req_bridge_if #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_req_bridge.sv
// Bridges core req/gnt/r_valid transfers onto one APB3 master port,
// one transfer in flight, with a pready timeout that reports an error.
//
// state  | meaning
// IDLE   | waiting for data_req_i; gnt follows req combinationally
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready or timeout
module apb_req_bridge
  import apb_req_bridge_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        data_req_i,
  input  logic [APB_ADDR_WIDTH-1:0]   data_add_i,
  input  logic                        data_we_i,
  input  logic [APB_DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [APB_DATA_WIDTH/8-1:0] data_be_i,
  output logic                        data_gnt_o,
  output logic                        data_r_valid_o,
  output logic [APB_DATA_WIDTH-1:0]   data_r_rdata_o,
  output logic                        data_r_opc_o,
  apb_req_bridge_if.master            apb
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      opc_q, opc_d;
  logic                      gnt_c;
  logic                      timeout_hit;

  // APB3 carries no strobes, so byte enables are intentionally dropped.
  logic unused_be;
  assign unused_be = ^data_be_i;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    opc_d    = opc_q;
    gnt_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_c = data_req_i;
        if (data_req_i) begin
          paddr_d  = data_add_i;
          pwdata_d = data_wdata_i;
          pwrite_d = data_we_i;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready has priority over a timeout firing in the same cycle.
        if (apb.pready) begin
          rvalid_d = 1'b1;
          rdata_d  = pwrite_q ? '0 : apb.prdata;
          opc_d    = apb.pslverr;
          state_d  = IDLE;
        end else if (timeout_hit) begin
          rvalid_d = 1'b1;
          rdata_d  = APB_DATA_WIDTH'(TIMEOUT_RDATA);
          opc_d    = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      opc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      opc_q    <= opc_d;
    end
  end

  assign data_gnt_o     = gnt_c & rst_ni;
  assign data_r_valid_o = rvalid_q;
  assign data_r_rdata_o = rdata_q;
  assign data_r_opc_o   = opc_q;

  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.psel    = (state_q != IDLE);
  assign apb.penable = (state_q == ACCESS);

endmodule

// File: tb/tb_apb_req_bridge.sv
// Scoreboard bench: two bridges (timeout 4 and timeout disabled) with bench-driven APB slaves.
module tb_apb_req_bridge;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic [31:0] rdata;
    logic        opc;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic          req, req0, we;
  logic [AW-1:0] add;
  logic [DW-1:0] wdata;
  logic [3:0]    be;
  logic          gnt, rv, opc, gnt0, rv0, opc0;
  logic [DW-1:0] rdata, rdata0;

  int          wait_a, wait_0;
  logic [31:0] rd_a, rd_0;
  logic        err_a;

  exp_t q[$];
  exp_t q0[$];

  apb_req_bridge_if #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();
  apb_req_bridge_if #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus0 ();

  apb_req_bridge #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_add_i(add), .data_we_i(we),
    .data_wdata_i(wdata), .data_be_i(be), .data_gnt_o(gnt), .data_r_valid_o(rv),
    .data_r_rdata_o(rdata), .data_r_opc_o(opc), .apb(bus.master));

  apb_req_bridge #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req0), .data_add_i(add), .data_we_i(we),
    .data_wdata_i(wdata), .data_be_i(be), .data_gnt_o(gnt0), .data_r_valid_o(rv0),
    .data_r_rdata_o(rdata0), .data_r_opc_o(opc0), .apb(bus0.master));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Slave models: pready in ACCESS cycle wait+1; wait = -1 never answers.
  initial begin
    int acc;
    acc = 0;
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
    forever begin
      @(negedge clk);
      if (bus.psel && bus.penable) acc++; else acc = 0;
      bus.pready  = bus.penable && (acc == wait_a + 1);
      bus.pslverr = bus.pready && err_a;
      bus.prdata  = rd_a;
    end
  end

  initial begin
    int acc;
    acc = 0;
    bus0.pready = 1'b0; bus0.pslverr = 1'b0; bus0.prdata = '0;
    forever begin
      @(negedge clk);
      if (bus0.psel && bus0.penable) acc++; else acc = 0;
      bus0.pready  = bus0.penable && (acc == wait_0 + 1);
      bus0.pslverr = 1'b0;
      bus0.prdata  = rd_0;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rv) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rvalid actual=1 required=0 cyc=%0d", cyc);
        end else begin
          e = q.pop_front();
          check("rdata", rdata, e.rdata);
          check("opc", {31'd0, opc}, {31'd0, e.opc});
          check("rvalid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rv0) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rvalid0 actual=1 required=0 cyc=%0d", cyc);
        end else begin
          e = q0.pop_front();
          check("rdata0", rdata0, e.rdata);
          check("opc0", {31'd0, opc0}, {31'd0, e.opc});
          check("rvalid_cycle0", cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, output int t);
    @(posedge clk); #1;
    req = 1'b1; we = w; add = a; wdata = d;
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      @(negedge clk);
      if (gnt) t = cyc;
    end
    if (t < 0) begin
      total++; bad++;
      $display("FAIL gnt_timeout actual=0 required=1");
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  initial begin
    int t;
    req = 1'b1; req0 = 1'b1; we = 1'b0; add = '0; wdata = '0; be = 4'hF;
    wait_a = -1; wait_0 = -1; rd_a = '0; rd_0 = '0; err_a = 1'b0;
    #3;
    check("rst_gnt", {31'd0, gnt}, 32'd0);
    check("rst_gnt0", {31'd0, gnt0}, 32'd0);
    check("rst_psel", {31'd0, bus.psel}, 32'd0);
    check("rst_penable", {31'd0, bus.penable}, 32'd0);
    check("rst_pwrite", {31'd0, bus.pwrite}, 32'd0);
    check("rst_paddr", bus.paddr, 32'd0);
    check("rst_pwdata", bus.pwdata, 32'd0);
    check("rst_rvalid", {31'd0, rv}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_opc", {31'd0, opc}, 32'd0);
    check("rst_psel0", {31'd0, bus0.psel}, 32'd0);
    req = 1'b0; req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-wait read
    wait_a = 0; rd_a = 32'hCAFE_F00D; err_a = 1'b0;
    issue(1'b0, 32'h1A10_0004, 32'h0, t);
    q.push_back('{32'hCAFE_F00D, 1'b0, t + 3});
    @(negedge clk);
    check("rd_setup_psel", {31'd0, bus.psel}, 32'd1);
    check("rd_setup_penable", {31'd0, bus.penable}, 32'd0);
    check("rd_paddr", bus.paddr, 32'h1A10_0004);
    check("rd_pwrite", {31'd0, bus.pwrite}, 32'd0);
    @(negedge clk);
    check("rd_access_psel", {31'd0, bus.psel}, 32'd1);
    check("rd_access_penable", {31'd0, bus.penable}, 32'd1);
    repeat (3) @(posedge clk);

    // Write with 3 wait states; address/data must hold through ACCESS
    wait_a = 3; rd_a = 32'hFFFF_FFFF;
    issue(1'b1, 32'h1A10_1000, 32'h1234_5678, t);
    q.push_back('{32'h0, 1'b0, t + 6});
    @(negedge clk);
    check("wr_setup_pwrite", {31'd0, bus.pwrite}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("wr_penable", {31'd0, bus.penable}, 32'd1);
      check("wr_paddr", bus.paddr, 32'h1A10_1000);
      check("wr_pwdata", bus.pwdata, 32'h1234_5678);
      check("wr_pwrite", {31'd0, bus.pwrite}, 32'd1);
    end
    repeat (3) @(posedge clk);

    // pslverr read, then back-to-back read with req held high
    wait_a = 0; err_a = 1'b1; rd_a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; add = 32'h1A10_0008;
    @(negedge clk);
    check("b2b_gnt1", {31'd0, gnt}, 32'd1);
    t = cyc;
    q.push_back('{32'hDEAD_BEEF, 1'b1, t + 3});
    @(posedge clk); #1;
    add = 32'h1A10_000C;
    @(negedge clk);
    check("b2b_nognt_setup", {31'd0, gnt}, 32'd0);
    @(negedge clk);
    check("b2b_nognt_access", {31'd0, gnt}, 32'd0);
    @(posedge clk); #1;
    err_a = 1'b0; rd_a = 32'h0BAD_CAFE;
    @(negedge clk);
    check("b2b_gnt2_with_rvalid", {31'd0, gnt & rv}, 32'd1);
    q.push_back('{32'h0BAD_CAFE, 1'b0, t + 6});
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("b2b_paddr2", bus.paddr, 32'h1A10_000C);
    repeat (4) @(posedge clk);

    // Timeout with a slave that never answers
    wait_a = -1; rd_a = 32'h5555_AAAA;
    issue(1'b0, 32'h1A10_0010, 32'h0, t);
    q.push_back('{32'h0, 1'b1, t + 7});
    repeat (4) @(negedge clk);
    check("to_psel_held", {31'd0, bus.psel}, 32'd1);
    repeat (5) @(posedge clk);

    // Async reset in the middle of ACCESS
    wait_a = -1;
    issue(1'b1, 32'h1A10_0020, 32'h0000_0077, t);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_penable_before", {31'd0, bus.penable}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_psel", {31'd0, bus.psel}, 32'd0);
    check("rst_mid_penable", {31'd0, bus.penable}, 32'd0);
    check("rst_mid_rvalid", {31'd0, rv}, 32'd0);
    check("rst_mid_paddr", bus.paddr, 32'd0);
    req = 1'b1;
    #1;
    check("rst_mid_gnt", {31'd0, gnt}, 32'd0);
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_a = 0; rd_a = 32'h1357_9BDF;
    repeat (5) @(posedge clk);
    issue(1'b0, 32'h1A10_0024, 32'h0, t);
    q.push_back('{32'h1357_9BDF, 1'b0, t + 3});
    repeat (4) @(posedge clk);

    // Timeout disabled: slave answers after 300 ACCESS cycles
    wait_0 = 299; rd_0 = 32'h0000_1300;
    @(posedge clk); #1;
    req0 = 1'b1; we = 1'b0; add = 32'h1A10_0040;
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      @(negedge clk);
      if (gnt0) t = cyc;
    end
    if (t < 0) begin
      total++; bad++;
      $display("FAIL gnt0_timeout actual=0 required=1");
    end
    q0.push_back('{32'h0000_1300, 1'b0, t + 302});
    @(posedge clk); #1;
    req0 = 1'b0;

    for (int i = 0; i < 400 && (q.size() != 0 || q0.size() != 0); i++) @(negedge clk);
    @(negedge clk);
    check("sb_drained", q.size(), 32'd0);
    check("sb0_drained", q0.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
